// File: rtl/fft_pkg.sv
// fft_pkg: shared twiddle field layout, fetch FSM states and FIFO depth.
package fft_pkg;
    localparam int TW_WIDTH      = 64;
    localparam int COS_MSB       = TW_WIDTH - 1;
    localparam int COS_LSB       = TW_WIDTH / 2;
    localparam int SIN_MSB       = TW_WIDTH / 2 - 1;
    localparam int SIN_LSB       = 0;
    localparam int TW_FIFO_DEPTH = 4;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
endpackage

// File: rtl/twiddle_fifo.sv
// twiddle_fifo: small synchronous FIFO holding returned ROM words with occupancy count.
module twiddle_fifo
    import fft_pkg::*;
#(
    parameter int W     = 74,
    parameter int DEPTH = TW_FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [W-1:0]  i_din,
    input  logic          i_pop,
    output logic [W-1:0]  o_dout,
    output logic [AW:0]   o_occ
);
    localparam logic [AW:0] ONE = 1;
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_occ;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wp  <= '0;
            r_rp  <= '0;
            r_occ <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wp] <= i_din;
                r_wp        <= r_wp + 1'b1;
            end
            if (i_pop) r_rp <= r_rp + 1'b1;
            r_occ <= r_occ + (i_push ? ONE : '0) - (i_pop ? ONE : '0);
        end
    end
    assign o_dout = r_mem[r_rp];
    assign o_occ  = r_occ;
endmodule

// File: rtl/twiddle_fetch.sv
// twiddle_fetch: issues per-stage twiddle ROM reads and streams the words out as valid/ready.
// Define TW_CONJ_EN to add the inverse port, which negates the sin field for inverse FFTs.
module twiddle_fetch
    import fft_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int N_LOG2  = 10,
    parameter int A_WIDTH = 9,
    parameter int S_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [S_WIDTH-1:0] stage,
`ifdef TW_CONJ_EN
    input  logic               inverse,
`endif
    output logic               busy,
    output logic               done,
    output logic               rom_en,
    output logic [A_WIDTH-1:0] rom_addr,
    input  logic [WIDTH-1:0]   rom_data,
    output logic               tw_valid,
    input  logic               tw_ready,
    output logic [WIDTH-1:0]   tw_data,
    output logic [A_WIDTH-1:0] tw_index,
    output logic               tw_last
);
    localparam int FW = WIDTH + A_WIDTH + 1;
    localparam int OW = $clog2(TW_FIFO_DEPTH) + 1;
    state_t             r_state;
    logic [N_LOG2-1:0]  r_issue, r_total;
    logic [S_WIDTH-1:0] r_shift;
    logic               r_rom_en, r_rom_last, r_dv, r_d_last;
    logic [A_WIDTH-1:0] r_rom_addr, r_rom_k, r_d_k;
    logic [OW-1:0]      w_occ;
    logic [FW-1:0]      w_head;
    logic [WIDTH-1:0]   w_word;
    logic               w_accept, w_room, w_more, w_issue, w_pop;
    assign w_accept = r_state == IDLE && start && 32'(stage) < N_LOG2;
    // Reads still in the rom_en register or ROM output stage count against FIFO space.
    assign w_room   = 4'(w_occ) + 4'(r_rom_en) + 4'(r_dv) < 4'(TW_FIFO_DEPTH);
    assign w_more   = r_issue != r_total;
    assign w_issue  = r_state == ISSUE && w_more && w_room;
    assign w_pop    = tw_valid && tw_ready;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_issue    <= '0;
            r_total    <= '0;
            r_shift    <= '0;
            r_rom_en   <= 1'b0;
            r_rom_addr <= '0;
            r_rom_k    <= '0;
            r_rom_last <= 1'b0;
            r_dv       <= 1'b0;
            r_d_k      <= '0;
            r_d_last   <= 1'b0;
        end else begin
            r_state  <= w_accept ? ISSUE : done ? IDLE : (r_state == ISSUE && !w_more) ? DRAIN : r_state;
            r_rom_en <= w_accept || w_issue;
            r_dv     <= r_rom_en;
            r_d_k    <= r_rom_k;
            r_d_last <= r_rom_last;
            if (w_accept) begin
                r_total    <= N_LOG2'(1) << stage;
                r_shift    <= S_WIDTH'(N_LOG2 - 1) - stage;
                r_issue    <= N_LOG2'(1);
                r_rom_addr <= '0;
                r_rom_k    <= '0;
                r_rom_last <= stage == '0;
            end else if (w_issue) begin
                r_issue    <= r_issue + 1'b1;
                r_rom_addr <= A_WIDTH'(r_issue << r_shift);
                r_rom_k    <= A_WIDTH'(r_issue);
                r_rom_last <= r_issue == r_total - 1'b1;
            end
        end
    end
    twiddle_fifo #(.W(FW), .DEPTH(TW_FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .i_push (r_dv),
        .i_din  ({rom_data, r_d_k, r_d_last}),
        .i_pop  (w_pop),
        .o_dout (w_head),
        .o_occ  (w_occ)
    );
    assign w_word   = w_head[FW-1:A_WIDTH+1];
    assign tw_valid = w_occ != '0;
    assign tw_index = w_head[A_WIDTH:1];
    assign tw_last  = w_head[0];
    assign done     = w_pop && tw_last;
    assign busy     = r_state != IDLE;
    assign rom_en   = r_rom_en;
    assign rom_addr = r_rom_addr;
`ifdef TW_CONJ_EN
    logic r_inv;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_inv <= 1'b0;
        else if (w_accept) r_inv <= inverse;
    end
    assign tw_data = r_inv ? {w_word[WIDTH-1:WIDTH/2], -w_word[WIDTH/2-1:0]} : w_word;
`else
    assign tw_data = w_word;
`endif
endmodule

// File: tb/tb_twiddle_fetch.sv
// tb_twiddle_fetch: scoreboard bench for twiddle_fetch with a 1-cycle {addr,~addr} ROM model.
module tb_twiddle_fetch;
    logic        clk = 0, rst = 1, start = 0, inverse = 0, tw_ready = 1;
    logic [3:0]  stage = 0;
    logic        busy, done, rom_en, tw_valid, tw_last;
    logic [8:0]  rom_addr, tw_index;
    logic [63:0] rom_data = '0, tw_data;
    typedef struct packed {logic [63:0] d; logic [8:0] k; logic l;} exp_t;
    exp_t       eq[$];
    logic [8:0] aq[$];
    exp_t       e, pv;
    logic       ps = 0;
    bit         rnd = 0;
    int         n_vec = 0, n_err = 0, done_cnt = 0;

    twiddle_fetch dut (
        .clk(clk), .rst(rst), .start(start), .stage(stage),
`ifdef TW_CONJ_EN
        .inverse(inverse),
`endif
        .busy(busy), .done(done), .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .tw_valid(tw_valid), .tw_ready(tw_ready), .tw_data(tw_data), .tw_index(tw_index),
        .tw_last(tw_last)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [63:0] word(logic [8:0] a, logic inv);
        logic [31:0] c, s;
        c = {23'b0, a};
        s = ~c;
        return {c, inv ? -s : s};
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail(string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s", nm);
    endtask

    always @(posedge clk) if (rom_en) rom_data <= word(rom_addr, 1'b0);

    initial forever begin
        @(posedge clk);
        #2 tw_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: address order, twiddle order, stall stability and done alignment.
    always @(negedge clk) begin
        if (rst) ps = 0;
        else begin
            if (rom_en) begin
                if (aq.size() == 0) fail("rom_addr_unexpected");
                else chk("rom_addr", rom_addr, aq.pop_front());
            end
            if (ps) begin
                chk("stall_valid", tw_valid, 1);
                chk("stall_data", tw_data, pv.d);
                chk("stall_idx_last", {tw_index, tw_last}, {pv.k, pv.l});
            end
            if (tw_valid && tw_ready) begin
                if (eq.size() == 0) fail("tw_unexpected");
                else begin
                    e = eq.pop_front();
                    chk("tw_data", tw_data, e.d);
                    chk("tw_index", tw_index, e.k);
                    chk("tw_last", tw_last, e.l);
                end
            end
            if (done || (tw_valid && tw_ready && tw_last))
                chk("done_pulse", done, tw_valid && tw_ready && tw_last);
            if (done) done_cnt++;
            ps = tw_valid && !tw_ready;
            pv = {tw_data, tw_index, tw_last};
        end
    end

    task automatic launch(int s, logic inv);
        int n = 1 << s;
        for (int k = 0; k < n; k++) begin
            logic [8:0] a;
            a = 9'(k << (9 - s));
            aq.push_back(a);
            eq.push_back({word(a, inv), 9'(k), k == n - 1});
        end
        @(negedge clk);
        stage = 4'(s);
        inverse = inv;
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic run_stage(int s, logic inv, bit r, bit poke);
        int n = 1 << s;
        int c = 0;
        int d0 = done_cnt;
        rnd = r;
        launch(s, inv);
        chk("start_rom_en", rom_en, 1);
        chk("start_busy", busy, 1);
        @(negedge clk);
        chk("valid_early", tw_valid, 0);
        @(negedge clk);
        chk("valid_latency", tw_valid, 1);
        if (poke) begin
            start = 1;
            stage = 4'd1;
        end
        while (!done && c < 3000) begin
            @(negedge clk);
            start = 0;
            c++;
        end
        if (c >= 3000) fail("done_timeout");
        if (!r) chk("throughput_cycles", 64'(c), 64'(n - 1));
        @(negedge clk);
        #1;
        chk("busy_after_done", busy, 0);
        chk("queue_drained", 64'(eq.size() + aq.size()), 0);
        chk("done_count", 64'(done_cnt - d0), 1);
        rnd = 0;
    endtask

    initial begin
        int d0;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rom", {rom_en, rom_addr}, 0);
        chk("rst_tw", {tw_valid, tw_last, tw_index}, 0);
        run_stage(0, 0, 0, 0);
        run_stage(3, 0, 0, 1);
        run_stage(9, 0, 0, 0);
        run_stage(9, 0, 1, 0);
        // Out-of-range stage must not start anything.
        @(negedge clk);
        stage = 4'd10;
        start = 1;
        @(negedge clk);
        start = 0;
        chk("bad_stage_busy", busy, 0);
        chk("bad_stage_rom_en", rom_en, 0);
        @(negedge clk);
        chk("bad_stage_valid", tw_valid, 0);
        // Asynchronous abort in the middle of stage 5.
        d0 = done_cnt;
        launch(5, 0);
        repeat (6) @(negedge clk);
        #2 rst = 1;
        #1;
        chk("abort_busy_done", {busy, done}, 0);
        chk("abort_rom", {rom_en, rom_addr}, 0);
        chk("abort_tw", {tw_valid, tw_last, tw_index}, 0);
        eq.delete();
        aq.delete();
        @(negedge clk);
        rst = 0;
        chk("abort_no_done", 64'(done_cnt - d0), 0);
        run_stage(2, 0, 0, 0);
`ifdef TW_CONJ_EN
        run_stage(2, 1, 0, 0);
        run_stage(0, 1, 0, 0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
